// File: rtl/nvm_pkg.sv
// nvm_pkg
// Shared types and constants for the NVM write controller.
//   nvm_wr_state_t : controller state encoding
//   DEF_DATA_W     : default word width
//   DEF_PROG_CYCLES: default program pulse length in clk cycles
//   cnt_width()    : width of the shared bit/pulse counter
// Optional feature macro: NVM_WRITER_VERIFY_EN adds the VERIFY state.
package nvm_pkg;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_PROG_CYCLES = 8;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_SHIFT,
    WR_PROG,
`ifdef NVM_WRITER_VERIFY_EN
    WR_VERIFY,
`endif
    WR_DONE
  } nvm_wr_state_t;

  // One counter serves both the bit count and the pulse count, so it has to
  // hold the larger of the two terminal values.
  function automatic int cnt_width(input int data_w, input int prog_cycles);
    int m;
    m = (data_w > prog_cycles) ? data_w : prog_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/nvm_wr_counter.sv
// nvm_wr_counter
// Saturating up-counter with terminal-count compare.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count enable
//   term       : terminal value to compare against
//   at_term    : high while the count equals term
module nvm_wr_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         at_term
);

  logic [W-1:0] count;

  // Saturate at all-ones so a stray enable can never wrap back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

  assign at_term = (count == term);

endmodule

// File: rtl/nvm_writer.sv
// nvm_writer
// Write-side controller for the serial NVM interface: shifts a word in MSB
// first, presents it to the array and drives a timed program pulse.
//   clk, rst_n  : clock, async active-low reset
//   write_en    : start request, only looked at in IDLE
//   sdi         : serial data in, sampled while sdi_ready is high
//   sdi_ready   : one cycle per data bit
//   nvm_wdata   : assembled word (qualify with prog)
//   prog        : program strobe to the array
//   busy        : high in every state but IDLE
//   done        : one-cycle completion pulse
// With NVM_WRITER_VERIFY_EN defined a one-cycle read-back follows the pulse:
//   nvm_rd      : read strobe
//   nvm_rdata   : read-back data
//   verify_err  : read-back mismatch, held until the next start
module nvm_writer
  import nvm_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int PROG_CYCLES = DEF_PROG_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_en,
  input  logic              sdi,
  output logic              sdi_ready,
  output logic [DATA_W-1:0] nvm_wdata,
  output logic              prog,
  output logic              busy,
  output logic              done
`ifdef NVM_WRITER_VERIFY_EN
  ,
  output logic              nvm_rd,
  input  logic [DATA_W-1:0] nvm_rdata,
  output logic              verify_err
`endif
);

  localparam int CW = cnt_width(DATA_W, PROG_CYCLES);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] PROG_LAST  = CW'(PROG_CYCLES - 1);

  nvm_wr_state_t state, state_next;
  logic [DATA_W-1:0] sreg;
  logic cnt_clr, cnt_en, at_term;
  logic [CW-1:0] cnt_term;

  nvm_wr_counter #(.W(CW)) u_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .term    (cnt_term),
    .at_term (at_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WR_IDLE;
    else        state <= state_next;
  end

  // The counter is cleared on every state entry that uses it, so the
  // terminal compare is against "last index" (N-1) of the current phase.
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    cnt_term   = PROG_LAST;
    case (state)
      WR_IDLE: begin
        if (write_en) begin
          state_next = WR_SHIFT;
          cnt_clr    = 1'b1;
        end
      end
      WR_SHIFT: begin
        cnt_term = SHIFT_LAST;
        cnt_en   = 1'b1;
        if (at_term) begin
          state_next = WR_PROG;
          cnt_clr    = 1'b1;
        end
      end
      WR_PROG: begin
        cnt_en = 1'b1;
        if (at_term) begin
`ifdef NVM_WRITER_VERIFY_EN
          state_next = WR_VERIFY;
`else
          state_next = WR_DONE;
`endif
          cnt_clr = 1'b1;
        end
      end
`ifdef NVM_WRITER_VERIFY_EN
      WR_VERIFY: state_next = WR_DONE;
`endif
      WR_DONE: state_next = WR_IDLE;
      default: state_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                sreg <= '0;
    else if (state == WR_SHIFT) sreg <= {sreg[DATA_W-2:0], sdi};
  end

`ifdef NVM_WRITER_VERIFY_EN
  // Flag survives the done pulse and idle time; only a new start clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              verify_err <= 1'b0;
    else if ((state == WR_IDLE) && write_en) verify_err <= 1'b0;
    else if (state == WR_VERIFY)             verify_err <= (nvm_rdata != sreg);
  end

  assign nvm_rd = (state == WR_VERIFY);
`endif

  // Strobes decode the async-reset state register directly, so rst_n low
  // kills prog/nvm_rd immediately without waiting for a clock edge.
  assign sdi_ready = (state == WR_SHIFT);
  assign prog      = (state == WR_PROG);
  assign busy      = (state != WR_IDLE);
  assign done      = (state == WR_DONE);
  assign nvm_wdata = sreg;

endmodule

// File: tb/tb_nvm_writer.sv
// tb_nvm_writer
// Self-checking bench for nvm_writer with DATA_W = 8, PROG_CYCLES = 4.
// Expected timing is derived from cycle numbers counted from the start edge.
// Build with NVM_WRITER_VERIFY_EN defined to cover the read-back path.
module tb_nvm_writer;

  localparam int DW = 8;
  localparam int PC = 4;
`ifdef NVM_WRITER_VERIFY_EN
  localparam int VX = 1;
`else
  localparam int VX = 0;
`endif
  localparam int DONE_CYC = DW + PC + 1 + VX;
  localparam int OBS      = DONE_CYC + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic write_en = 1'b0;
  logic sdi = 1'b0;
  logic sdi_ready, prog, busy, done;
  logic [DW-1:0] nvm_wdata;
`ifdef NVM_WRITER_VERIFY_EN
  logic nvm_rd, verify_err;
  logic [DW-1:0] nvm_rdata = '0;
  logic [DW-1:0] exp_rdata = '0;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  nvm_writer #(.DATA_W(DW), .PROG_CYCLES(PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .write_en   (write_en),
    .sdi        (sdi),
    .sdi_ready  (sdi_ready),
    .nvm_wdata  (nvm_wdata),
    .prog       (prog),
    .busy       (busy),
    .done       (done)
`ifdef NVM_WRITER_VERIFY_EN
    ,
    .nvm_rd     (nvm_rd),
    .nvm_rdata  (nvm_rdata),
    .verify_err (verify_err)
`endif
  );

  // Free-running cycle count and event monitor sampled away from the edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int last_prog_cyc = 0, rise_cyc = 0, rise_cnt = 0;
  int done_cnt = 0, ready_cnt = 0, prog_cnt = 0;
  logic ready_q = 1'b0;
  always @(negedge clk) begin
    ready_q <= sdi_ready;
    if (sdi_ready && !ready_q) begin
      rise_cyc <= cyc;
      rise_cnt <= rise_cnt + 1;
    end
    if (sdi_ready) ready_cnt <= ready_cnt + 1;
    if (prog) begin
      last_prog_cyc <= cyc;
      prog_cnt <= prog_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  // Observations of one transaction, indexed by cycle number after E0.
  logic obs_ready [0:OBS];
  logic obs_prog  [0:OBS];
  logic obs_busy  [0:OBS];
  logic obs_done  [0:OBS];
  logic [DW-1:0] obs_wdata [0:OBS];
`ifdef NVM_WRITER_VERIFY_EN
  logic obs_rd  [0:OBS];
  logic obs_err [0:OBS];
`endif

  // Caller must be at a negedge with the DUT idle. Returns at the negedge of
  // the idle cycle after done, with write_en still high if keep_we is set.
  task automatic drive_write(input logic [DW-1:0] word, input bit keep_we);
    write_en = 1'b1;
`ifdef NVM_WRITER_VERIFY_EN
    nvm_rdata = exp_rdata;
`endif
    @(posedge clk);
    for (int k = 1; k <= OBS; k++) begin
      @(negedge clk);
      if (!keep_we) write_en = 1'b0;
      obs_ready[k] = sdi_ready;
      obs_prog[k]  = prog;
      obs_busy[k]  = busy;
      obs_done[k]  = done;
      obs_wdata[k] = nvm_wdata;
`ifdef NVM_WRITER_VERIFY_EN
      obs_rd[k]  = nvm_rd;
      obs_err[k] = verify_err;
`endif
      if (k <= DW) sdi = word[DW-k];
      else         sdi = 1'($urandom);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    write_en = 1'b1;
    repeat (2) @(negedge clk);
    compared++; if (sdi_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_sdi_ready: got %b expected 0", sdi_ready); end
    compared++; if (prog !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_prog: got %b expected 0", prog); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    compared++; if (nvm_wdata !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_wdata: got %h expected 00", nvm_wdata); end
`ifdef NVM_WRITER_VERIFY_EN
    compared++; if (nvm_rd !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_nvm_rd: got %b expected 0", nvm_rd); end
    compared++; if (verify_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_verify_err: got %b expected 0", verify_err); end
`endif
    write_en = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_after_reset_busy: got %b expected 0", busy); end
  endtask

  // Full per-cycle timeline against the cycle-number model, random words.
  task automatic test_basic();
    logic [DW-1:0] word;
    bit e_ready, e_prog, e_busy, e_done;
    for (int t = 0; t < 4; t++) begin
      word = (t == 0) ? 8'hA5 : 8'($urandom);
`ifdef NVM_WRITER_VERIFY_EN
      exp_rdata = (t == 1) ? (word ^ 8'(1 << $urandom_range(7, 0))) : ((t == 3) ? 8'($urandom) : word);
`endif
      @(negedge clk);
      drive_write(word, 1'b0);
      for (int k = 1; k <= OBS; k++) begin
        e_ready = (k >= 1) && (k <= DW);
        e_prog  = (k > DW) && (k <= DW + PC);
        e_done  = (k == DONE_CYC);
        e_busy  = (k <= DONE_CYC);
        compared++; if (obs_ready[k] !== e_ready) begin mismatched++; $display("[TB] FAIL basic_sdi_ready t%0d c%0d: got %b expected %b", t, k, obs_ready[k], e_ready); end
        compared++; if (obs_prog[k] !== e_prog) begin mismatched++; $display("[TB] FAIL basic_prog t%0d c%0d: got %b expected %b", t, k, obs_prog[k], e_prog); end
        compared++; if (obs_done[k] !== e_done) begin mismatched++; $display("[TB] FAIL basic_done t%0d c%0d: got %b expected %b", t, k, obs_done[k], e_done); end
        compared++; if (obs_busy[k] !== e_busy) begin mismatched++; $display("[TB] FAIL basic_busy t%0d c%0d: got %b expected %b", t, k, obs_busy[k], e_busy); end
        if (e_prog) begin
          compared++; if (obs_wdata[k] !== word) begin mismatched++; $display("[TB] FAIL basic_wdata t%0d c%0d: got %h expected %h", t, k, obs_wdata[k], word); end
        end
`ifdef NVM_WRITER_VERIFY_EN
        compared++; if (obs_rd[k] !== (k == DW + PC + 1)) begin mismatched++; $display("[TB] FAIL basic_nvm_rd t%0d c%0d: got %b expected %b", t, k, obs_rd[k], (k == DW + PC + 1)); end
        compared++; if (obs_err[k] !== ((k >= DONE_CYC) && (exp_rdata != word))) begin mismatched++; $display("[TB] FAIL basic_verify_err t%0d c%0d: got %b expected %b", t, k, obs_err[k], ((k >= DONE_CYC) && (exp_rdata != word))); end
`endif
      end
    end
  endtask

  // write_en held high for 20 edges: one transaction per IDLE entry only.
  task automatic test_hold_we();
    int r0, d0, y0, p0, n_exp, waited;
    @(negedge clk);
    r0 = rise_cnt; d0 = done_cnt; y0 = ready_cnt; p0 = prog_cnt;
    // Starts land on edges 1, 1+OBS, ... that still see write_en high.
    n_exp = (20 - 1) / OBS + 1;
`ifdef NVM_WRITER_VERIFY_EN
    exp_rdata = 8'($urandom);
    nvm_rdata = exp_rdata;
`endif
    write_en = 1'b1;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk);
      #2 sdi = 1'($urandom);
    end
    write_en = 1'b0;
    waited = 0;
    @(negedge clk);
    while (busy && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL hold_timeout: busy still %b after %0d cycles", busy, waited); end
    @(posedge clk); #2;
    compared++; if (rise_cnt - r0 !== n_exp) begin mismatched++; $display("[TB] FAIL hold_starts: got %0d expected %0d", rise_cnt - r0, n_exp); end
    compared++; if (done_cnt - d0 !== n_exp) begin mismatched++; $display("[TB] FAIL hold_dones: got %0d expected %0d", done_cnt - d0, n_exp); end
    compared++; if (ready_cnt - y0 !== n_exp * DW) begin mismatched++; $display("[TB] FAIL hold_ready_cycles: got %0d expected %0d", ready_cnt - y0, n_exp * DW); end
    compared++; if (prog_cnt - p0 !== n_exp * PC) begin mismatched++; $display("[TB] FAIL hold_prog_cycles: got %0d expected %0d", prog_cnt - p0, n_exp * PC); end
  endtask

  // Reset during the 2nd prog cycle, then a clean write of 0x3C.
  task automatic test_reset_mid_prog();
    logic [DW-1:0] word;
    int d0;
    word = 8'($urandom);
    @(negedge clk);
    d0 = done_cnt;
    write_en = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= DW + 1; k++) begin
      @(negedge clk);
      write_en = 1'b0;
      if (k <= DW) sdi = word[DW-k];
    end
    @(posedge clk);
    #2;
    compared++; if (prog !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_prog_before: got %b expected 1", prog); end
    rst_n = 1'b0;
    #1;
    compared++; if (prog !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_prog_immediate: got %b expected 0", prog); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_busy_immediate: got %b expected 0", busy); end
    compared++; if (nvm_wdata !== 8'h00) begin mismatched++; $display("[TB] FAIL rst_wdata_discarded: got %h expected 00", nvm_wdata); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    compared++; if (done_cnt !== d0) begin mismatched++; $display("[TB] FAIL rst_no_done: got %0d done pulses expected %0d", done_cnt, d0); end
`ifdef NVM_WRITER_VERIFY_EN
    exp_rdata = 8'h3C;
`endif
    drive_write(8'h3C, 1'b0);
    for (int k = DW + 1; k <= DW + PC; k++) begin
      compared++; if (obs_prog[k] !== 1'b1 || obs_wdata[k] !== 8'h3C) begin mismatched++; $display("[TB] FAIL rst_rewrite_wdata c%0d: got prog %b data %h expected prog 1 data 3c", k, obs_prog[k], obs_wdata[k]); end
    end
    compared++; if (obs_done[DONE_CYC] !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_rewrite_done: got %b expected 1", obs_done[DONE_CYC]); end
`ifdef NVM_WRITER_VERIFY_EN
    compared++; if (obs_err[DONE_CYC] !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_rewrite_verify_err: got %b expected 0", obs_err[DONE_CYC]); end
`endif
  endtask

`ifdef NVM_WRITER_VERIFY_EN
  task automatic test_verify();
    exp_rdata = 8'hA5;
    @(negedge clk);
    drive_write(8'hA5, 1'b0);
    compared++; if (obs_rd[DW + PC + 1] !== 1'b1) begin mismatched++; $display("[TB] FAIL verify_rd_strobe: got %b expected 1", obs_rd[DW + PC + 1]); end
    compared++; if (obs_err[DONE_CYC] !== 1'b0) begin mismatched++; $display("[TB] FAIL verify_match: got %b expected 0", obs_err[DONE_CYC]); end
    exp_rdata = 8'hA4;
    @(negedge clk);
    drive_write(8'hA5, 1'b0);
    compared++; if (obs_err[DONE_CYC] !== 1'b1) begin mismatched++; $display("[TB] FAIL verify_mismatch_done: got %b expected 1", obs_err[DONE_CYC]); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      compared++; if (verify_err !== 1'b1) begin mismatched++; $display("[TB] FAIL verify_err_hold i%0d: got %b expected 1", i, verify_err); end
    end
    exp_rdata = 8'h5A;
    drive_write(8'h5A, 1'b0);
    compared++; if (obs_err[1] !== 1'b0) begin mismatched++; $display("[TB] FAIL verify_err_clear_at_start: got %b expected 0", obs_err[1]); end
  endtask
`endif

  // 0xFF then 0x00 with the second start taken at the earliest legal edge.
  task automatic test_back_to_back();
    int lp, gap;
`ifdef NVM_WRITER_VERIFY_EN
    exp_rdata = 8'hFF;
`endif
    @(negedge clk);
    drive_write(8'hFF, 1'b0);
    for (int k = DW + 1; k <= DW + PC; k++) begin
      compared++; if (obs_wdata[k] !== 8'hFF) begin mismatched++; $display("[TB] FAIL b2b_wdata_ff c%0d: got %h expected ff", k, obs_wdata[k]); end
    end
    lp = last_prog_cyc;
`ifdef NVM_WRITER_VERIFY_EN
    exp_rdata = 8'h00;
`endif
    drive_write(8'h00, 1'b0);
    for (int k = DW + 1; k <= DW + PC; k++) begin
      compared++; if (obs_wdata[k] !== 8'h00) begin mismatched++; $display("[TB] FAIL b2b_wdata_00 c%0d: got %h expected 00", k, obs_wdata[k]); end
    end
    @(posedge clk); #2;
    gap = rise_cyc - lp - 1;
    compared++; if (gap !== 2 + VX) begin mismatched++; $display("[TB] FAIL b2b_gap: got %0d cycles expected %0d", gap, 2 + VX); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_we();
    test_reset_mid_prog();
`ifdef NVM_WRITER_VERIFY_EN
    test_verify();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
